// File: rtl/vc_net_reorder_buffer_pkg.sv
// Shared constants and message-width helper for the network reorder buffer.
// Layout matches the test network message: {dest, src, opaque, payload}, dest in the MSBs.
package vc_net_reorder_buffer_pkg;

  localparam int unsigned DEF_PAYLOAD_NBITS = 8;
  localparam int unsigned DEF_OPAQUE_NBITS  = 8;
  localparam int unsigned DEF_SRCDEST_NBITS = 2;
  localparam int unsigned DEF_NUM_ENTRIES   = 8;

  function automatic int unsigned vc_net_msg_nbits(input int unsigned p,
                                                   input int unsigned o,
                                                   input int unsigned s);
    return p + o + 2 * s;
  endfunction

endpackage

// File: rtl/vc_net_reorder_slot_array.sv
// n-entry message storage with one write port, one read port and a valid vector
// (set on write, cleared on read-release).
module vc_net_reorder_slot_array #(
  parameter int unsigned p_msg_nbits   = 20,
  parameter int unsigned p_num_entries = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [$clog2(p_num_entries)-1:0] wr_idx,
  input  logic [p_msg_nbits-1:0]           wr_data,
  input  logic                             rd_clr,
  input  logic [$clog2(p_num_entries)-1:0] rd_idx,
  output logic [p_msg_nbits-1:0]           rd_data,
  output logic [p_num_entries-1:0]         valid
);

  logic [p_msg_nbits-1:0] mem [p_num_entries];

  // Payload storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_idx] <= 1'b1;
      if (rd_clr) valid[rd_idx] <= 1'b0;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/vc_net_reorder_buffer.sv
// Restores ascending opaque (sequence number) order on a test-network output port.
// Optional window checking/drop counting is enabled by defining VC_NET_REORDER_CHECK_EN.
module vc_net_reorder_buffer
  import vc_net_reorder_buffer_pkg::*;
#(
  parameter int unsigned p_payload_nbits = DEF_PAYLOAD_NBITS,
  parameter int unsigned p_opaque_nbits  = DEF_OPAQUE_NBITS,
  parameter int unsigned p_srcdest_nbits = DEF_SRCDEST_NBITS,
  parameter int unsigned p_num_entries   = DEF_NUM_ENTRIES
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_val,
  output logic                                   in_rdy,
  input  logic [vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)-1:0] in_msg,
  output logic                                   out_val,
  input  logic                                   out_rdy,
  output logic [vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)-1:0] out_msg,
  output logic [$clog2(p_num_entries):0]         occupancy,
  output logic [15:0]                            err_count
);

  localparam int unsigned MSG_NBITS = vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits,
                                                       p_srcdest_nbits);
  localparam int unsigned IDX_NBITS = $clog2(p_num_entries);
  localparam int unsigned OCC_NBITS = IDX_NBITS + 1;
  localparam int unsigned OPQ_LSB   = p_payload_nbits;

  logic [p_opaque_nbits-1:0] head;
  logic [IDX_NBITS-1:0]      in_idx;
  logic [IDX_NBITS-1:0]      head_idx;
  logic [p_num_entries-1:0]  valid;
  logic [MSG_NBITS-1:0]      rd_data;
  logic [OCC_NBITS-1:0]      occ_q;
  logic                      wr_en;
  logic                      rel;

  assign in_idx   = in_msg[OPQ_LSB +: IDX_NBITS];
  assign head_idx = head[IDX_NBITS-1:0];

`ifdef VC_NET_REORDER_CHECK_EN
  localparam logic [p_opaque_nbits:0] WIN_LIMIT = (p_opaque_nbits + 1)'(p_num_entries);

  logic [p_opaque_nbits-1:0] delta;
  logic                      in_window;
  logic [15:0]               err_q;

  // Modular distance from the next expected sequence number.
  assign delta     = in_msg[OPQ_LSB +: p_opaque_nbits] - head;
  assign in_window = ({1'b0, delta} < WIN_LIMIT);
  assign in_rdy    = ~valid[in_idx] | ~in_window;
  assign wr_en     = in_val & in_rdy & in_window;

  // Out-of-window messages are consumed and counted, never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (in_val && in_rdy && !in_window && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign in_rdy    = ~valid[in_idx];
  assign wr_en     = in_val & in_rdy;
  assign err_count = '0;
`endif

  assign out_val = valid[head_idx];
  assign out_msg = rd_data;
  assign rel     = out_val & out_rdy;

  vc_net_reorder_slot_array #(
    .p_msg_nbits   (MSG_NBITS),
    .p_num_entries (p_num_entries)
  ) u_slots (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (in_idx),
    .wr_data (in_msg),
    .rd_clr  (rel),
    .rd_idx  (head_idx),
    .rd_data (rd_data),
    .valid   (valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
    end else if (rel) begin
      head <= head + p_opaque_nbits'(1);
    end
  end

  // Accept and release in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      case ({wr_en, rel})
        2'b10:   occ_q <= occ_q + OCC_NBITS'(1);
        2'b01:   occ_q <= occ_q - OCC_NBITS'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_vc_net_reorder_buffer.sv
// Directed testbench for vc_net_reorder_buffer (default parameters).
module tb_vc_net_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [19:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [19:0] out_msg;
  logic [3:0]  occupancy;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  vc_net_reorder_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .occupancy (occupancy),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] mk(input logic [7:0] op, input logic [7:0] pl);
    return {2'd1, 2'd2, op, pl};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_msg  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %b exp 0", out_val); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b exp 1", in_rdy); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
  endtask

  task automatic test_in_order;
    logic [7:0] pl [4];
    pl[0] = 8'hce; pl[1] = 8'hfe; pl[2] = 8'h09; pl[3] = 8'hdf;
    do_reset();
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = mk(8'd0, pl[0]);
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL inorder_val[%0d] got %b exp 1", k, out_val); end
      checks++; if (out_msg !== mk(8'(k), pl[k])) begin errors++; $display("FAIL inorder_msg[%0d] got %h exp %h", k, out_msg, mk(8'(k), pl[k])); end
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL inorder_occ[%0d] got %0d exp 1", k, occupancy); end
      if (k < 3) in_msg = mk(8'(k + 1), pl[k + 1]);
      else       in_val = 1'b0;
      step();
    end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL inorder_end_val got %b exp 0", out_val); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL inorder_end_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_reversal;
    do_reset();
    out_rdy = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      in_val = 1'b1;
      in_msg = mk(8'(k), 8'(k * 16 + 3));
      #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rev_in_rdy[%0d] got %b exp 1", k, in_rdy); end
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL rev_early_val[%0d] got %b exp 0", k, out_val); end
      @(posedge clk);
      #1;
      checks++; if (occupancy !== 4'(8 - k)) begin errors++; $display("FAIL rev_occ[%0d] got %0d exp %0d", k, occupancy, 8 - k); end
    end
    in_val = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL rev_drain_val[%0d] got %b exp 1", j, out_val); end
      checks++; if (out_msg !== mk(8'(j), 8'(j * 16 + 3))) begin errors++; $display("FAIL rev_drain_msg[%0d] got %h exp %h", j, out_msg, mk(8'(j), 8'(j * 16 + 3))); end
      step();
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rev_end_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_wraparound;
    int exp_seq;
    int s;
    exp_seq = 0;
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 260; i++) begin
      s      = i ^ 1;
      in_val = 1'b1;
      in_msg = mk(8'(s), 8'(s * 7 + 5));
      #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL wrap_in_rdy[%0d] got %b exp 1", i, in_rdy); end
      @(posedge clk);
      #1;
      if (out_val === 1'b1) begin
        checks++; if (out_msg !== mk(8'(exp_seq), 8'(exp_seq * 7 + 5))) begin errors++; $display("FAIL wrap_msg[%0d] got %h exp %h", exp_seq, out_msg, mk(8'(exp_seq), 8'(exp_seq * 7 + 5))); end
        exp_seq++;
      end
    end
    in_val = 1'b0;
    for (int c = 0; c < 20 && exp_seq < 260; c++) begin
      step();
      if (out_val === 1'b1) begin
        checks++; if (out_msg !== mk(8'(exp_seq), 8'(exp_seq * 7 + 5))) begin errors++; $display("FAIL wrap_msg[%0d] got %h exp %h", exp_seq, out_msg, mk(8'(exp_seq), 8'(exp_seq * 7 + 5))); end
        exp_seq++;
      end
    end
    checks++; if (exp_seq !== 260) begin errors++; $display("FAIL wrap_count got %0d exp 260", exp_seq); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_val = 1'b1;
      in_msg = mk(8'(k), 8'(k * 16 + 3));
      step();
    end
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL bp_occ_full got %0d exp 8", occupancy); end
    in_msg = mk(8'd8, 8'(8 * 16 + 3));
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_val[%0d] got %b exp 1", c, out_val); end
      checks++; if (out_msg !== mk(8'd0, 8'd3)) begin errors++; $display("FAIL bp_msg[%0d] got %h exp %h", c, out_msg, mk(8'd0, 8'd3)); end
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d] got %b exp 0", c, in_rdy); end
      step();
    end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_resume_rdy got %b exp 1", in_rdy); end
    checks++; if (out_msg !== mk(8'd1, 8'd19)) begin errors++; $display("FAIL bp_next_msg got %h exp %h", out_msg, mk(8'd1, 8'd19)); end
    step();
    in_val = 1'b0;
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL bp_occ_refill got %0d exp 8", occupancy); end
    out_rdy = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      checks++; if (out_msg !== mk(8'(j), 8'(j * 16 + 3)) || out_val !== 1'b1) begin errors++; $display("FAIL bp_drain[%0d] got %b/%h exp 1/%h", j, out_val, out_msg, mk(8'(j), 8'(j * 16 + 3))); end
      step();
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL bp_end_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_out_of_window;
    do_reset();
    out_rdy = 1'b0;
`ifdef VC_NET_REORDER_CHECK_EN
    in_val = 1'b1;
    in_msg = mk(8'd8, 8'h55);
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL oow_rdy8 got %b exp 1", in_rdy); end
    step();
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL oow_err1 got %0d exp 1", err_count); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL oow_occ1 got %0d exp 0", occupancy); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL oow_val1 got %b exp 0", out_val); end
    in_msg = mk(8'd0, 8'h10);
    step();
    in_val  = 1'b0;
    checks++; if (out_msg !== mk(8'd0, 8'h10)) begin errors++; $display("FAIL oow_msg0 got %h exp %h", out_msg, mk(8'd0, 8'h10)); end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_msg  = mk(8'd0, 8'h77);
    step();
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL oow_err2 got %0d exp 2", err_count); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL oow_occ2 got %0d exp 0", occupancy); end
    in_msg = mk(8'd1, 8'h11);
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1 || out_msg !== mk(8'd1, 8'h11)) begin errors++; $display("FAIL oow_msg1 got %b/%h exp 1/%h", out_val, out_msg, mk(8'd1, 8'h11)); end
`else
    in_val = 1'b1;
    in_msg = mk(8'd0, 8'h10);
    step();
    in_msg = mk(8'd8, 8'h55);
    #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL alias_stall got %b exp 0", in_rdy); end
    step();
    in_val = 1'b0;
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL nochk_err got %0d exp 0", err_count); end
    checks++; if (out_msg !== mk(8'd0, 8'h10)) begin errors++; $display("FAIL alias_msg got %h exp %h", out_msg, mk(8'd0, 8'h10)); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL alias_occ got %0d exp 1", occupancy); end
`endif
  endtask

  task automatic test_reset_midstream;
    do_reset();
    out_rdy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_val = 1'b1;
      in_msg = mk(8'(k), 8'(k + 32));
      step();
    end
    in_val = 1'b0;
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL mid_occ_pre got %0d exp 3", occupancy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mid_val got %b exp 0", out_val); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL mid_occ got %0d exp 0", occupancy); end
    in_val = 1'b1;
    in_msg = mk(8'd0, 8'hab);
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1 || out_msg !== mk(8'd0, 8'hab)) begin errors++; $display("FAIL mid_post_msg got %b/%h exp 1/%h", out_val, out_msg, mk(8'd0, 8'hab)); end
    out_rdy = 1'b1;
    step();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mid_discard got %b exp 0", out_val); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL mid_end_occ got %0d exp 0", occupancy); end
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_msg  = '0;
    test_reset();
    test_in_order();
    test_reversal();
    test_wraparound();
    test_backpressure();
    test_out_of_window();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
